game_timer: RTL

Countdown game clock for the scoreboard. It consumes the one-cycle 1 Hz `tick` strobe from the upstream clock divider and counts a preset MM:SS time down to 00:00 in BCD. Start/stop, pause and reload are driven from debounced button pulses. Its four BCD digits feed the seven-segment display stage. The expiry outputs feed the buzzer/horn logic.

---
 rtl/game_timer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/game_timer.sv
`default_nettype none
// ============================================================================
//  Module   : game_timer
//  Purpose  : Countdown game clock. Counts a preset MM:SS down to 00:00 in
//             BCD, one second per 1 Hz tick strobe, with start/stop (run /
//             pause toggle) and load (reload preset, return to IDLE).
//  Ports    : clk, reset       - system clock, synchronous active-high reset
//             tick             - one-cycle 1 Hz enable strobe
//             start_stop       - one-cycle pulse, toggles run/pause
//             load             - one-cycle pulse, reload preset -> IDLE
//             min_tens/min_ones/sec_tens/sec_ones - BCD digits (registered)
//             running          - high while counting
//             done             - high while expired
//             expired          - one-cycle pulse as done first rises
//  Revision : 1.0 - initial release
// ============================================================================
module game_timer #(
    parameter int PRESET_MIN = 12,
    parameter int PRESET_SEC = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       load,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       expired
);

    // Preset digits resolved at elaboration; no run-time division.
    localparam logic [3:0] c_PRE_MT = 4'(PRESET_MIN / 10);
    localparam logic [3:0] c_PRE_MO = 4'(PRESET_MIN % 10);
    localparam logic [3:0] c_PRE_ST = 4'(PRESET_SEC / 10);
    localparam logic [3:0] c_PRE_SO = 4'(PRESET_SEC % 10);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_mt, r_mo, r_st, r_so;
    logic [3:0] w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
    logic [3:0] w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
    logic       w_borrow_so, w_borrow_st, w_borrow_mo;
    logic       w_is_zero, w_is_one;
    logic       r_running, r_done, r_expired;
    logic       w_expired_nxt;

    // ---------------------------------------------------------------------
    // One-second BCD decrement. Each higher digit moves only when every
    // digit below it borrows. min_tens has no wrap: 00:00 never decrements.
    // ---------------------------------------------------------------------
    always_comb begin
        w_borrow_so = (r_so == 4'd0);
        w_dec_so    = w_borrow_so ? 4'd9 : (r_so - 4'd1);

        w_borrow_st = w_borrow_so && (r_st == 4'd0);
        w_dec_st    = !w_borrow_so ? r_st :
                      (r_st == 4'd0) ? 4'd5 : (r_st - 4'd1);

        w_borrow_mo = w_borrow_st && (r_mo == 4'd0);
        w_dec_mo    = !w_borrow_st ? r_mo :
                      (r_mo == 4'd0) ? 4'd9 : (r_mo - 4'd1);

        w_dec_mt    = w_borrow_mo ? (r_mt - 4'd1) : r_mt;
    end

    assign w_is_zero = (r_mt == 4'd0) && (r_mo == 4'd0) &&
                       (r_st == 4'd0) && (r_so == 4'd0);
    assign w_is_one  = (r_mt == 4'd0) && (r_mo == 4'd0) &&
                       (r_st == 4'd0) && (r_so == 4'd1);

    // ---------------------------------------------------------------------
    // Next state / next digits. load beats start_stop beats tick.
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_mt_nxt      = r_mt;
        w_mo_nxt      = r_mo;
        w_st_nxt      = r_st;
        w_so_nxt      = r_so;
        w_expired_nxt = 1'b0;

        if (load) begin
            w_state_nxt = S_IDLE;
            w_mt_nxt    = c_PRE_MT;
            w_mo_nxt    = c_PRE_MO;
            w_st_nxt    = c_PRE_ST;
            w_so_nxt    = c_PRE_SO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A zero preset has nothing to count; stay put.
                    if (start_stop && !w_is_zero)
                        w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (start_stop) begin
                        w_state_nxt = S_PAUSED;
                    end else if (tick) begin
                        if (w_is_zero) begin
                            // Unreachable in normal flow; never wrap below 00:00.
                            w_state_nxt   = S_EXPIRED;
                            w_expired_nxt = 1'b1;
                        end else begin
                            w_mt_nxt = w_dec_mt;
                            w_mo_nxt = w_dec_mo;
                            w_st_nxt = w_dec_st;
                            w_so_nxt = w_dec_so;
                            if (w_is_one) begin
                                w_state_nxt   = S_EXPIRED;
                                w_expired_nxt = 1'b1;
                            end
                        end
                    end
                end
                S_PAUSED: begin
                    if (start_stop)
                        w_state_nxt = S_RUN;
                end
                S_EXPIRED: begin
                    w_mt_nxt = 4'd0;
                    w_mo_nxt = 4'd0;
                    w_st_nxt = 4'd0;
                    w_so_nxt = 4'd0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Registers. running/done are derived from the next state so they
    // change on the same edge as the state itself.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mt      <= c_PRE_MT;
            r_mo      <= c_PRE_MO;
            r_st      <= c_PRE_ST;
            r_so      <= c_PRE_SO;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mt      <= w_mt_nxt;
            r_mo      <= w_mo_nxt;
            r_st      <= w_st_nxt;
            r_so      <= w_so_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_EXPIRED);
            r_expired <= w_expired_nxt;
        end
    end

    assign min_tens = r_mt;
    assign min_ones = r_mo;
    assign sec_tens = r_st;
    assign sec_ones = r_so;
    assign running  = r_running;
    assign done     = r_done;
    assign expired  = r_expired;

endmodule
`default_nettype wire
